// File: rtl/ahb_pkg.sv
// Shared types and constants for the two-master AHB-Lite arbiter.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic M_I = 1'b0;
    localparam logic M_D = 1'b1;

    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; remembers the last granted master.
module rr_arbiter2
    import ahb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       winner,
    output logic       last_winner
);

    always_comb begin
        winner = M_I;
        if (req == 2'b11) winner = ~last_winner;
        else if (req[1])  winner = M_D;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)        last_winner <= M_I;
        else if (grant_en) last_winner <= winner;
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Shares one AHB-Lite slave between fetch (I) and load/store (D),
// one transfer outstanding, with a data-phase timeout.
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int LENGTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [LENGTH-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [LENGTH-1:0] d_addr,
    input  logic [LENGTH-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [LENGTH-1:0] rdata,
    output logic              err,
    output logic [LENGTH-1:0] HADDR,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    output logic [LENGTH-1:0] HWDATA,
    input  logic [LENGTH-1:0] HRDATA,
    input  logic              HREADY
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e            state, state_next;
    logic              owner;
    logic              we_q;
    logic [LENGTH-1:0] addr_q, wdata_q;
    logic [CW-1:0]     wait_cnt;
    logic [1:0]        req;
    logic              any_req, done, abort, grant_en;
    logic              winner, last_winner;

    assign req      = {d_req, i_req};
    assign any_req  = |req;
    assign done     = (state == ST_DATA) && HREADY;
    assign abort    = (state == ST_DATA) && !HREADY
                      && (wait_cnt == CW'(TIMEOUT - 1));
    assign grant_en = any_req && ((state == ST_IDLE) || done);

    rr_arbiter2 u_arb (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .grant_en    (grant_en),
        .winner      (winner),
        .last_winner (last_winner)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (any_req) state_next = ST_ADDR;
            ST_ADDR: if (HREADY) state_next = ST_DATA;
            ST_DATA: begin
                if (done)       state_next = any_req ? ST_ADDR : ST_IDLE;
                else if (abort) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            owner    <= M_I;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wait_cnt <= '0;
            rdata    <= '0;
            i_valid  <= 1'b0;
            d_valid  <= 1'b0;
            err      <= 1'b0;
        end else begin
            state   <= state_next;
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            err     <= 1'b0;
            if (grant_en) begin
                owner <= winner;
                if (winner == M_D) begin
                    addr_q  <= d_addr;
                    we_q    <= d_we;
                    wdata_q <= d_wdata;
                end else begin
                    addr_q  <= i_addr;
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                end
            end
            if ((state == ST_ADDR) && HREADY)
                wait_cnt <= '0;
            else if ((state == ST_DATA) && !HREADY)
                wait_cnt <= wait_cnt + CW'(1);
            if (done || abort) begin
                rdata   <= done ? HRDATA : LENGTH'(ERR_DATA);
                err     <= abort;
                i_valid <= (owner == M_I);
                d_valid <= (owner == M_D);
            end
        end
    end

    // Address-phase outputs are decoded from state so reset clears them at once.
    assign HTRANS = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR  = addr_q;
    assign HWRITE = (state == ST_ADDR) && we_q;
    assign HWDATA = wdata_q;
    assign i_gnt  = (state == ST_ADDR) && (owner == M_I);
    assign d_gnt  = (state == ST_ADDR) && (owner == M_D);

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter; completions are checked
// against a scoreboard filled as each request is driven.
module tb_ahb_bus_arbiter;

    logic        clock, reset;
    logic        i_req, i_gnt, i_valid;
    logic [31:0] i_addr;
    logic        d_req, d_we, d_gnt, d_valid;
    logic [31:0] d_addr, d_wdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HWRITE, HREADY;
    logic [1:0]  HTRANS;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        logic        chk_data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    ahb_bus_arbiter #(.LENGTH(32), .TIMEOUT(16)) dut (
        .clock   (clock),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_gnt   (i_gnt),
        .i_valid (i_valid),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_gnt   (d_gnt),
        .d_valid (d_valid),
        .rdata   (rdata),
        .err     (err),
        .HADDR   (HADDR),
        .HWRITE  (HWRITE),
        .HTRANS  (HTRANS),
        .HWDATA  (HWDATA),
        .HRDATA  (HRDATA),
        .HREADY  (HREADY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic is_d, input logic [31:0] data,
                        input logic chk_data, input logic er);
        exp_t x;
        x.is_d     = is_d;
        x.data     = data;
        x.chk_data = chk_data;
        x.err      = er;
        sb.push_back(x);
    endtask

    // Completion monitor and mutual-exclusion checks.
    always @(posedge clock) begin
        #1;
        chk("excl_gnt", 32'(i_gnt & d_gnt), 32'd0);
        chk("excl_valid", 32'(i_valid & d_valid), 32'd0);
        if (i_valid || d_valid) begin
            chk("sb_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_who", 32'(d_valid), 32'(e.is_d));
                chk("sb_err", 32'(err), 32'(e.err));
                if (e.chk_data) chk("sb_rdata", rdata, e.data);
            end
        end
    end

    initial begin
        reset   = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        HRDATA  = '0;
        HREADY  = 1'b1;
        repeat (2) cyc();
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ctrl", {26'd0, HWRITE, i_gnt, d_gnt, i_valid, d_valid, err},
            32'd0);
        reset = 1'b1;
        cyc();

        // single fetch, zero wait
        i_req  = 1'b1;
        i_addr = 32'h100;
        HRDATA = 32'h00500093;
        push(1'b0, 32'h00500093, 1'b1, 1'b0);
        cyc();
        chk("f_haddr", HADDR, 32'h100);
        chk("f_htrans", 32'(HTRANS), 32'd2);
        chk("f_gnt", 32'({i_gnt, d_gnt}), 32'd2);
        i_req = 1'b0;
        cyc();
        chk("f_data_htrans", 32'(HTRANS), 32'd0);
        chk("f_data_gnt", 32'(i_gnt), 32'd0);
        cyc();
        chk("f_valid", 32'(i_valid), 32'd1);
        chk("f_rdata", rdata, 32'h00500093);
        chk("f_err", 32'(err), 32'd0);
        cyc();
        chk("f_valid_pulse", 32'(i_valid), 32'd0);

        // write, one address wait and two data waits
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h2000_0004;
        d_wdata = 32'hA5;
        HRDATA  = 32'h1111_2222;
        push(1'b1, 32'h0, 1'b0, 1'b0);
        cyc();
        chk("w_gnt", 32'({i_gnt, d_gnt}), 32'd1);
        chk("w_hwrite", 32'(HWRITE), 32'd1);
        chk("w_haddr", HADDR, 32'h2000_0004);
        d_req  = 1'b0;
        d_we   = 1'b0;
        HREADY = 1'b0;
        cyc();
        chk("w_addr_hold_gnt", 32'(d_gnt), 32'd1);
        chk("w_addr_hold_htrans", 32'(HTRANS), 32'd2);
        HREADY = 1'b1;
        cyc();
        HREADY = 1'b0;
        chk("w_data_gnt", 32'(d_gnt), 32'd0);
        chk("w_hwdata0", HWDATA, 32'hA5);
        cyc();
        chk("w_hwdata1", HWDATA, 32'hA5);
        chk("w_no_valid1", 32'(d_valid), 32'd0);
        cyc();
        HREADY = 1'b1;
        chk("w_hwdata2", HWDATA, 32'hA5);
        chk("w_no_valid2", 32'(d_valid), 32'd0);
        cyc();
        chk("w_valid", 32'(d_valid), 32'd1);
        cyc();

        // contention after reset: D, I, D, I
        reset = 1'b0;
        cyc();
        reset  = 1'b1;
        i_req  = 1'b1;
        i_addr = 32'h300;
        d_req  = 1'b1;
        d_addr = 32'h400;
        cyc();
        for (int k = 0; k < 4; k++) begin
            chk("c_gnt", 32'({i_gnt, d_gnt}), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("c_haddr", HADDR, (k % 2 == 0) ? 32'h400 : 32'h300);
            HRDATA = 32'hC0DE_0000 + 32'(k);
            push((k % 2 == 0), HRDATA, 1'b1, 1'b0);
            if (k == 3) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
            cyc();
            cyc();
        end

        // data-phase timeout
        i_req  = 1'b1;
        i_addr = 32'h500;
        push(1'b0, 32'hDEADBEEF, 1'b1, 1'b1);
        cyc();
        chk("t_gnt", 32'(i_gnt), 32'd1);
        i_req = 1'b0;
        cyc();
        HREADY = 1'b0;
        for (int n = 0; n < 16; n++) begin
            chk("t_no_valid", 32'(i_valid), 32'd0);
            cyc();
        end
        chk("t_valid", 32'(i_valid), 32'd1);
        chk("t_err", 32'(err), 32'd1);
        chk("t_rdata", rdata, 32'hDEADBEEF);
        chk("t_htrans", 32'(HTRANS), 32'd0);
        HREADY = 1'b1;
        cyc();
        chk("t_idle_htrans", 32'(HTRANS), 32'd0);
        chk("t_err_pulse", 32'(err), 32'd0);

        // reset during a data wait state
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h600;
        d_wdata = 32'h77;
        cyc();
        d_req = 1'b0;
        d_we  = 1'b0;
        cyc();
        HREADY = 1'b0;
        cyc();
        #2;
        reset = 1'b0;
        #1;
        chk("r_htrans", 32'(HTRANS), 32'd0);
        chk("r_haddr", HADDR, 32'd0);
        chk("r_hwdata", HWDATA, 32'd0);
        chk("r_rdata", rdata, 32'd0);
        chk("r_ctrl", {27'd0, HWRITE, d_gnt, d_valid, i_valid, err}, 32'd0);
        cyc();
        chk("r_no_valid", 32'(d_valid), 32'd0);
        HREADY = 1'b1;
        reset  = 1'b1;
        i_req  = 1'b1;
        i_addr = 32'h700;
        HRDATA = 32'h1234_5678;
        push(1'b0, 32'h1234_5678, 1'b1, 1'b0);
        cyc();
        chk("r_gnt", 32'(i_gnt), 32'd1);
        chk("r_new_haddr", HADDR, 32'h700);
        i_req = 1'b0;
        cyc();
        cyc();
        chk("r_valid", 32'(i_valid), 32'd1);
        chk("r_new_rdata", rdata, 32'h1234_5678);

        // back-to-back fetch then data
        i_req  = 1'b1;
        i_addr = 32'h800;
        HRDATA = 32'hAAAA_0001;
        push(1'b0, 32'hAAAA_0001, 1'b1, 1'b0);
        cyc();
        i_req = 1'b0;
        cyc();
        d_req  = 1'b1;
        d_addr = 32'h900;
        push(1'b1, 32'hBBBB_0002, 1'b1, 1'b0);
        cyc();
        chk("b_dgnt", 32'(d_gnt), 32'd1);
        chk("b_htrans", 32'(HTRANS), 32'd2);
        chk("b_haddr", HADDR, 32'h900);
        chk("b_ivalid", 32'(i_valid), 32'd1);
        d_req  = 1'b0;
        HRDATA = 32'hBBBB_0002;
        cyc();
        cyc();
        chk("b_dvalid", 32'(d_valid), 32'd1);
        chk("b_rdata", rdata, 32'hBBBB_0002);
        repeat (2) cyc();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Two-master, one-slave AHB-Lite arbiter and transfer sequencer for the single-cycle core.
- Masters: the instruction-fetch port (I) and the load/store port (D).
- Replaces the static HADDR select mux so fetch and data accesses share one bus with wait states.
- Only one transfer is outstanding at a time; the core stalls on the grant/valid handshake.

Parameters:
- LENGTH, 32: address and data width.
- TIMEOUT, 16: consecutive HREADY-low cycles in the data phase before the transfer is aborted.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held until i_gnt.
- i_addr  in  LENGTH  fetch address.
- i_gnt  out  1  one-cycle pulse: fetch address phase issued.
- i_valid  out  1  one-cycle pulse: fetch complete.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = write.
- d_addr  in  LENGTH  data address.
- d_wdata  in  LENGTH  write data.
- d_gnt  out  1  one-cycle pulse: data address phase issued.
- d_valid  out  1  one-cycle pulse: data transfer complete.
- rdata  out  LENGTH  read data; valid with i_valid or d_valid.
- err  out  1  qualifies i_valid/d_valid: transfer timed out.
- HADDR  out  LENGTH  bus address.
- HWRITE  out  1  bus write.
- HTRANS  out  2  bus transfer type: 00 IDLE, 10 NONSEQ.
- HWDATA  out  LENGTH  bus write data.
- HRDATA  in  LENGTH  bus read data.
- HREADY  in  1  slave ready.

Behaviour:
- Reset (asynchronous, reset=0), all outputs forced immediately, including mid-transfer with no completion pulse:
  - HTRANS=00; HADDR, HWDATA, rdata = 0; HWRITE, gnts, valids, err = 0.
  - state=IDLE; last_winner=I.
- Requests are sampled on rising edges. Requesters hold addr, we and wdata stable from req until gnt, then may change or drop them.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - No request: stay in IDLE.
  - Any request: register the winner's addr, we and wdata; go to ADDR.
- Arbitration when both requesters are asserted: round-robin; winner = master not equal to last_winner. A single requester always wins. last_winner updates on every grant.
- ADDR:
  - Drive HTRANS=10, HADDR and HWRITE (I always reads); pulse the winner's gnt this cycle.
  - HREADY=1: go to DATA.
  - HREADY=0: hold outputs, stay in ADDR, and keep gnt asserted. gnt deasserts after the cycle where HREADY=1, so it is high for exactly the cycles of the address phase.
- DATA:
  - Drive HTRANS=00 and HWDATA = registered wdata. Increment the wait counter each cycle HREADY=0.
  - On HREADY=1:
    - Register HRDATA into rdata (writes register it too; don't-care).
    - Next cycle: pulse the owner's valid with err=0.
    - Next state: if any req is asserted this cycle, arbitrate and go directly to ADDR (back-to-back); else go to IDLE.
  - Wait counter reaches TIMEOUT (HREADY low TIMEOUT cycles):
    - Abort: next cycle pulse valid with err=1 and rdata=0xDEADBEEF.
    - Go to IDLE; arbitration resumes from IDLE.
- Latency with zero-wait slave:
  - req seen at edge 0; gnt in cycle 1; DATA in cycle 2; valid in cycle 3.
  - Back-to-back transfers every 2 cycles.
- rdata holds its value between valid pulses. i_valid and d_valid are never high together; same for the two gnts.
- A request raised while the other master's transfer is in flight waits; there is no preemption.
- Wait counter width: clog2(TIMEOUT+1); cleared on entering DATA.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10.
  - FSM state encoding IDLE/ADDR/DATA.
  - Master IDs M_I=0, M_D=1.
  - ERR_DATA=32'hDEADBEEF.
- One sub-module, rr_arbiter2: inputs req[1:0], last_winner, grant_en; outputs winner and the updated last_winner register. The main block holds the FSM, address/data registers and timeout counter.

Test Plan:
- Single fetch, zero wait: i_req=1, i_addr=0x100, HRDATA=0x00500093:
  - Cycle 1: HADDR=0x100, HTRANS=10, i_gnt=1.
  - Cycle 3: i_valid=1, rdata=0x00500093, err=0.
- Write with 2 wait states: d_req, d_we=1, d_addr=0x2000_0004, d_wdata=0xA5:
  - HWRITE=1 in ADDR; HWDATA=0xA5 through DATA while HREADY low for 2 cycles.
  - d_valid exactly 1 cycle after HREADY rises.
- Contention: i_req and d_req held high for 4 transfers after reset → grant order D, I, D, I; addresses match each grantee; no double gnt or valid.
- Timeout (TIMEOUT=16): HREADY held low in DATA for 16 cycles → valid with err=1, rdata=0xDEADBEEF, then FSM returns to IDLE with HTRANS=00.
- Reset mid-DATA: assert reset during a wait state → outputs go to reset values immediately with no valid pulse. After release, a new i_req completes normally.
- Back-to-back: d_req asserted during the DATA cycle of a fetch → d_gnt in the cycle right after DATA (no IDLE cycle in between).
